// File: rtl/quadrature_decoder.sv
// Quadrature decoder: 2-FF sync, per-channel stability filter, x4 decode, illegal-transition count.
// Optional step-period measurement is enabled by defining QDEC_PERIOD_EN.
module quadrature_decoder #(
    parameter int unsigned POS_WIDTH    = 32,
    parameter int unsigned FILTER_LEN   = 4,
    parameter int unsigned PERIOD_WIDTH = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        encoder_a,
    input  logic                        encoder_b,
    input  logic                        clear,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        dir,
    output logic                        step_pulse,
    output logic [15:0]                 err_cnt,
    output logic                        err_sticky,
    output logic [PERIOD_WIDTH-1:0]     period,
    output logic                        period_valid
);

    // Channel vectors are {A, B}
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] filt;
    logic [1:0] prev_q;
    logic [1:0] prime_cnt_q;
    logic       primed_q;
    logic       prime_load;

    assign prime_load = !primed_q && (prime_cnt_q == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            prime_cnt_q <= 2'd0;
            primed_q    <= 1'b0;
            prev_q      <= 2'b00;
        end else begin
            sync1_q <= {encoder_a, encoder_b};
            sync2_q <= sync1_q;
            if (prime_load) begin
                primed_q <= 1'b1;
                prev_q   <= sync2_q;
            end else if (!primed_q) begin
                prime_cnt_q <= prime_cnt_q + 2'd1;
            end else begin
                prev_q <= filt;
            end
        end
    end

    generate
        if (FILTER_LEN == 0) begin : g_nofilt
            assign filt = sync2_q;
        end else begin : g_filt
            localparam int unsigned CW = $clog2(FILTER_LEN + 1);
            logic [1:0]         filt_q;
            logic [1:0][CW-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    filt_q <= 2'b00;
                    cnt_q  <= '0;
                end else if (!primed_q) begin
                    if (prime_load) filt_q <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        if (sync2_q[i] != filt_q[i]) begin
                            if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
                                filt_q[i] <= sync2_q[i];
                                cnt_q[i]  <= '0;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                        end else begin
                            cnt_q[i] <= '0;
                        end
                    end
                end
            end

            assign filt = filt_q;
        end
    endgenerate

    logic fwd, rev, illegal;

    always_comb begin
        fwd     = 1'b0;
        rev     = 1'b0;
        illegal = 1'b0;
        if (primed_q) begin
            case ({prev_q, filt})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd = 1'b1;
                4'b0001, 4'b0111, 4'b1110, 4'b1000: rev = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
                default: ;
            endcase
        end
    end

    logic signed [POS_WIDTH-1:0] pos_q, pos_d;
    logic                        dir_q, dir_d;
    logic                        step_q, step_d;
    logic [15:0]                 err_q, err_d;
    logic                        sticky_q, sticky_d;

    // clear wins over anything decoded in the same cycle
    always_comb begin
        pos_d    = pos_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        err_d    = err_q;
        sticky_d = sticky_q;
        if (clear) begin
            pos_d    = '0;
            err_d    = '0;
            sticky_d = 1'b0;
        end else if (fwd) begin
            pos_d  = pos_q + POS_WIDTH'(1);
            dir_d  = 1'b1;
            step_d = 1'b1;
        end else if (rev) begin
            pos_d  = pos_q - POS_WIDTH'(1);
            dir_d  = 1'b0;
            step_d = 1'b1;
        end else if (illegal) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q    <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign position   = pos_q;
    assign dir        = dir_q;
    assign step_pulse = step_q;
    assign err_cnt    = err_q;
    assign err_sticky = sticky_q;

`ifdef QDEC_PERIOD_EN
    logic [PERIOD_WIDTH-1:0] pcnt_q, period_q;
    logic                    pvalid_q, seen_q;

    // First counted step only restarts the counter; there is no previous step to measure from
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q   <= '0;
            period_q <= '0;
            pvalid_q <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            pvalid_q <= 1'b0;
            if (step_d) begin
                pcnt_q <= '0;
                seen_q <= 1'b1;
                if (seen_q) begin
                    period_q <= (pcnt_q == '1) ? pcnt_q : pcnt_q + 1'b1;
                    pvalid_q <= 1'b1;
                end
            end else if (pcnt_q != '1) begin
                pcnt_q <= pcnt_q + 1'b1;
            end
        end
    end

    assign period       = period_q;
    assign period_valid = pvalid_q;
`else
    assign period       = {PERIOD_WIDTH{1'b0}};
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench: DUT1 (32-bit, filter 4) for latency/filter/illegal, DUT2 (8-bit, no filter)
// for wrap, saturation, clear and period checks.
module tb_quadrature_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a1 = 1'b1, b1 = 1'b1, clear1 = 1'b0;
    logic [31:0] pos1;
    logic        dir1, step1, sticky1, pv1;
    logic [15:0] err1;
    logic [23:0] per1;

    logic        a2 = 1'b1, b2 = 1'b1, clear2 = 1'b0;
    logic [7:0]  pos2;
    logic        dir2, step2_o, sticky2, pv2;
    logic [15:0] err2;
    logic [7:0]  per2;

    quadrature_decoder u_dut1 (
        .clk(clk), .reset(reset), .encoder_a(a1), .encoder_b(b1), .clear(clear1),
        .position(pos1), .dir(dir1), .step_pulse(step1), .err_cnt(err1),
        .err_sticky(sticky1), .period(per1), .period_valid(pv1)
    );

    quadrature_decoder #(.POS_WIDTH(8), .FILTER_LEN(0), .PERIOD_WIDTH(8)) u_dut2 (
        .clk(clk), .reset(reset), .encoder_a(a2), .encoder_b(b2), .clear(clear2),
        .position(pos2), .dir(dir2), .step_pulse(step2_o), .err_cnt(err2),
        .err_sticky(sticky2), .period(per2), .period_valid(pv2)
    );

    int total = 0;
    int bad = 0;
    int nstep1 = 0;
    always @(posedge clk) if (step1) nstep1 <= nstep1 + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            2'b00: return 2'b10;
            2'b10: return 2'b11;
            2'b11: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_next(input logic [1:0] s);
        case (s)
            2'b00: return 2'b01;
            2'b01: return 2'b11;
            2'b11: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [1:0] st2 = 2'b11;

    task automatic step2(input bit fwd, input int gap, output bit seen,
                         output logic [7:0] per, output bit pv);
        st2 = fwd ? fwd_next(st2) : rev_next(st2);
        a2 = st2[1];
        b2 = st2[0];
        seen = 1'b0;
        per = '0;
        pv = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
            if (step2_o && !seen) begin
                seen = 1'b1;
                per = per2;
                pv = pv2;
            end
        end
    endtask

    typedef struct {
        logic [1:0] ab;
        int         pos;
        logic       dir;
    } vec_t;

    vec_t vecs[44];

    initial begin
        logic [1:0] s;
        int p;
        int lat;
        int n0;
        bit seen;
        bit pv;
        logic [7:0] per;

        s = 2'b11;
        p = 0;
        for (int i = 0; i < 32; i++) begin
            s = fwd_next(s);
            p++;
            vecs[i] = '{s, p, 1'b1};
        end
        for (int i = 0; i < 12; i++) begin
            s = rev_next(s);
            p--;
            vecs[32 + i] = '{s, p, 1'b0};
        end

        // Reset with inputs held at 11; priming must not see a false 00->11
        cyc(3);
        reset = 1'b0;
        cyc(10);
        chk("reset_pos1", pos1, 0);
        chk("reset_err1", err1, 0);
        chk("reset_sticky1", sticky1, 0);
        chk("reset_dir1", dir1, 0);
        chk("reset_nstep1", nstep1, 0);
        chk("reset_err2", err2, 0);
        chk("reset_pos2", pos2, 0);
        chk("reset_per1", per1, 0);
        chk("reset_pv1", pv1, 0);

        // Table: 32 forward then 12 reverse edges, 20 clk apart, latency 7
        for (int i = 0; i < 44; i++) begin
            a1 = vecs[i].ab[1];
            b1 = vecs[i].ab[0];
            lat = 0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk);
                #1;
                if (step1 && lat == 0) lat = c;
            end
            chk($sformatf("vec%0d_lat", i), lat, 7);
            chk($sformatf("vec%0d_pos", i), pos1, 32'(vecs[i].pos));
            chk($sformatf("vec%0d_dir", i), dir1, vecs[i].dir);
        end
        chk("fwd_rev_nstep", nstep1, 44);

        // 2-cycle glitch on A is rejected
        n0 = nstep1;
        a1 = 1'b0;
        cyc(2);
        a1 = 1'b1;
        cyc(15);
        chk("glitch_nstep", nstep1, n0);
        chk("glitch_pos", pos1, 20);

        // Stable change counts exactly one step (11 -> 01 is forward)
        a1 = 1'b0;
        cyc(15);
        chk("stable_nstep", nstep1, n0 + 1);
        chk("stable_pos", pos1, 21);
        chk("stable_dir", dir1, 1);

        // Illegal 01 -> 10
        a1 = 1'b1;
        b1 = 1'b0;
        cyc(15);
        chk("ill_err", err1, 1);
        chk("ill_sticky", sticky1, 1);
        chk("ill_pos", pos1, 21);
        chk("ill_dir", dir1, 1);
        chk("ill_nstep", nstep1, n0 + 1);

        clear1 = 1'b1;
        cyc(1);
        clear1 = 1'b0;
        cyc(1);
        chk("clr1_err", err1, 0);
        chk("clr1_sticky", sticky1, 0);
        chk("clr1_pos", pos1, 0);
        chk("clr1_dir", dir1, 1);

        // 8-bit wrap on DUT2
        for (int i = 0; i < 127; i++) step2(1'b1, 4, seen, per, pv);
        chk("wrap_pos127", pos2, 8'h7F);
        step2(1'b1, 4, seen, per, pv);
        chk("wrap_step_seen", seen, 1);
        chk("wrap_pos80", pos2, 8'h80);
        clear2 = 1'b1;
        cyc(1);
        clear2 = 1'b0;
        cyc(1);
        chk("clr2_pos", pos2, 0);
        step2(1'b0, 4, seen, per, pv);
        chk("wrap_posFF", pos2, 8'hFF);
        chk("wrap_dir0", dir2, 0);

        // Clear lands on the decode cycle of a reverse step: result 0, not FE
        st2 = rev_next(st2);
        a2 = st2[1];
        b2 = st2[0];
        cyc(2);
        clear2 = 1'b1;
        cyc(1);
        clear2 = 1'b0;
        cyc(3);
        chk("clr_coinc_pos", pos2, 0);

        // Error counter saturation: both channels toggle every cycle
        for (int i = 0; i < 70000; i++) begin
            st2 = ~st2;
            a2 = st2[1];
            b2 = st2[0];
            cyc(1);
        end
        cyc(4);
        chk("sat_err", err2, 16'hFFFF);
        chk("sat_sticky", sticky2, 1);
        chk("sat_pos", pos2, 0);
        clear2 = 1'b1;
        cyc(1);
        clear2 = 1'b0;
        cyc(1);
        chk("sat_clr_err", err2, 0);
        chk("sat_clr_sticky", sticky2, 0);

`ifdef QDEC_PERIOD_EN
        step2(1'b1, 100, seen, per, pv);
        step2(1'b1, 100, seen, per, pv);
        chk("per_seen_a", seen, 1);
        chk("per_val_a", per, 100);
        chk("per_pv_a", pv, 1);
        step2(1'b1, 270, seen, per, pv);
        chk("per_val_b", per, 100);
        chk("per_pv_b", pv, 1);
        step2(1'b1, 10, seen, per, pv);
        chk("per_sat", per, 8'hFF);
        chk("per_pv_sat", pv, 1);
`else
        step2(1'b1, 10, seen, per, pv);
        chk("per_off_seen", seen, 1);
        chk("per_off_val", per, 0);
        chk("per_off_pv", pv, 0);
`endif

        // Reset mid-operation; priming repeats and the first step has no period
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(6);
        chk("rst2_pos1", pos1, 0);
        chk("rst2_pos2", pos2, 0);
        chk("rst2_err2", err2, 0);
        step2(1'b1, 10, seen, per, pv);
        chk("rst2_step_seen", seen, 1);
        chk("rst2_step_pv", pv, 0);
        chk("rst2_pos_after", pos2, 1);
        chk("rst2_dir", dir2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
